// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
package axi_rd_arb_pkg;

  typedef enum logic [0:0] {
    AR_IDLE,
    AR_PEND
  } ar_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;

  // Each beat fills the whole data bus.
  function automatic logic [2:0] calc_arsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI read master bundle (AR + R channels) between the arbiter and the SoC fabric.
interface axi_rd_arbiter_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 512
);
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARSIZE;
  logic [3:0]            ARLEN;
  logic [1:0]            ARBURST;
  logic [1:0]            ARLOCK;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARSIZE, ARLEN, ARBURST, ARLOCK, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARSIZE, ARLEN, ARBURST, ARLOCK, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: first request at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    gnt_idx_o
);

  logic            found;
  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IdxW'((32'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read master among NUM_REQ requesters; ARID carries the requester index.
// Optional watchdog on stalled R traffic is enabled with AXI_RD_ARB_WDOG_EN.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                          iSoCClk_reg,
  input  logic                          iSoCRst_n,
  input  logic [NUM_REQ-1:0]            iReqValid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iReqAddr,
  input  logic [NUM_REQ*4-1:0]          iReqLen,
  output logic [NUM_REQ-1:0]            oReqReady,
  output logic [NUM_REQ-1:0]            oRspValid,
  output logic [DATA_WIDTH-1:0]         oRspData,
  output logic [1:0]                    oRspResp,
  output logic                          oRspLast,
  input  logic [NUM_REQ-1:0]            iRspReady,
  axi_rd_arbiter_if.master              axi,
  output logic                          oIdErr,
  output logic                          oWdogErr
);

  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam logic [2:0]  ArSize = calc_arsize(DATA_WIDTH);

  if (NUM_REQ < 2 || NUM_REQ > 16 || ID_WIDTH < $clog2(NUM_REQ) || WDOG_CYCLES == 0)
  begin : g_bad_param
    $error("axi_rd_arbiter: unsupported parameter combination");
  end

  ar_state_e             state_q;
  logic [IdxW-1:0]       ar_id_q, ptr_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q, sel_addr;
  logic [3:0]            ar_len_q, sel_len;
  logic [NUM_REQ-1:0]    outstanding_q, outstanding_d, out_set, out_clr;
  logic [NUM_REQ-1:0]    eligible, gnt;
  logic [IdxW-1:0]       gnt_idx;
  logic                  id_err_q;
  logic                  rid_ok, r_hs;
  logic [IdxW-1:0]       rid_idx;

  // A requester with a burst in flight may not issue another.
  assign eligible = iReqValid & ~outstanding_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i     (eligible),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign oReqReady = (state_q == AR_IDLE) ? gnt : '0;

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = iReqAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = iReqLen[k*4 +: 4];
      end
    end
  end

  assign axi.ARVALID = (state_q == AR_PEND);
  assign axi.ARID    = ID_WIDTH'(ar_id_q);
  assign axi.ARADDR  = ar_addr_q;
  assign axi.ARLEN   = ar_len_q;
  assign axi.ARSIZE  = ArSize;
  assign axi.ARBURST = BURST_INCR;
  assign axi.ARLOCK  = LOCK_NORMAL;

  // R path: steer by RID; unknown IDs are drained and flagged.
  assign rid_ok     = 32'(axi.RID) < NUM_REQ;
  assign rid_idx    = axi.RID[IdxW-1:0];
  assign axi.RREADY = rid_ok ? iRspReady[rid_idx] : 1'b1;
  assign r_hs       = axi.RVALID & axi.RREADY;
  assign oRspData   = axi.RDATA;
  assign oRspResp   = axi.RRESP;
  assign oRspLast   = axi.RLAST;

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      oRspValid[k] = axi.RVALID && rid_ok && (rid_idx == IdxW'(k));
    end
  end

  always_comb begin
    out_set = '0;
    out_clr = '0;
    if (state_q == AR_PEND && axi.ARREADY) out_set[ar_id_q] = 1'b1;
    if (r_hs && axi.RLAST && rid_ok)       out_clr[rid_idx] = 1'b1;
    outstanding_d = (outstanding_q & ~out_clr) | out_set;
  end

  always_ff @(posedge iSoCClk_reg or negedge iSoCRst_n) begin
    if (!iSoCRst_n) begin
      state_q       <= AR_IDLE;
      ar_id_q       <= '0;
      ar_addr_q     <= '0;
      ar_len_q      <= '0;
      ptr_q         <= '0;
      outstanding_q <= '0;
      id_err_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (axi.RVALID && !rid_ok) id_err_q <= 1'b1;
      unique case (state_q)
        AR_IDLE: begin
          if (|eligible) begin
            ar_id_q   <= gnt_idx;
            ar_addr_q <= sel_addr;
            ar_len_q  <= sel_len;
            state_q   <= AR_PEND;
          end
        end
        AR_PEND: begin
          if (axi.ARREADY) begin
            ptr_q   <= (ar_id_q == IdxW'(NUM_REQ - 1)) ? '0 : ar_id_q + 1'b1;
            state_q <= AR_IDLE;
          end
        end
        default: state_q <= AR_IDLE;
      endcase
    end
  end

  assign oIdErr = id_err_q;

`ifdef AXI_RD_ARB_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_cnt_q;
  logic             wdog_err_q;
  logic             stall;

  assign stall = (|outstanding_q) && !r_hs;

  always_ff @(posedge iSoCClk_reg or negedge iSoCRst_n) begin
    if (!iSoCRst_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (!stall) begin
        wdog_cnt_q <= '0;
      end else if (wdog_cnt_q != WdogW'(WDOG_CYCLES)) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      end
      if (stall && wdog_cnt_q == WdogW'(WDOG_CYCLES - 1)) wdog_err_q <= 1'b1;
    end
  end

  assign oWdogErr = wdog_err_q;
`else
  assign oWdogErr = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (NUM_REQ=4, WDOG_CYCLES=16).
module tb_axi_rd_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned WD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*4-1:0] req_len;
  logic [DW-1:0]   rsp_data, exp_data;
  logic [1:0]      rsp_resp;
  logic            rsp_last, id_err, wdog_err;

  int checks = 0;
  int errors = 0;
  int exp_seq [5] = '{0, 1, 2, 3, 0};

  axi_rd_arbiter_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_rd_arbiter #(
    .NUM_REQ     (NR),
    .ID_WIDTH    (IW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .WDOG_CYCLES (WD)
  ) dut (
    .iSoCClk_reg (clk),
    .iSoCRst_n   (rst_n),
    .iReqValid   (req_valid),
    .iReqAddr    (req_addr),
    .iReqLen     (req_len),
    .oReqReady   (req_ready),
    .oRspValid   (rsp_valid),
    .oRspData    (rsp_data),
    .oRspResp    (rsp_resp),
    .oRspLast    (rsp_last),
    .iRspReady   (rsp_ready),
    .axi         (axi),
    .oIdErr      (id_err),
    .oWdogErr    (wdog_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_len = '0; rsp_ready = '0;
    axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RID = '0; axi.RDATA = '0;
    axi.RRESP = '0; axi.RLAST = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (axi.ARVALID !== 1'b0) begin errors++;
      $display("FAIL reset_arvalid got %b want 0", axi.ARVALID); end
    checks++; if (axi.ARID !== 4'd0) begin errors++;
      $display("FAIL reset_arid got %0d want 0", axi.ARID); end
    checks++; if (axi.ARADDR !== 32'd0) begin errors++;
      $display("FAIL reset_araddr got %h want 0", axi.ARADDR); end
    checks++; if (axi.ARLEN !== 4'd0) begin errors++;
      $display("FAIL reset_arlen got %0d want 0", axi.ARLEN); end
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'b0000 || axi.RREADY !== 1'b0) begin errors++;
      $display("FAIL reset_r_path got %b/%b want 0000/0", rsp_valid, axi.RREADY); end
    checks++; if (id_err !== 1'b0 || wdog_err !== 1'b0) begin errors++;
      $display("FAIL reset_err got %b/%b want 0/0", id_err, wdog_err); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req_addr[2*AW +: AW] = 32'h0000_1000;
    req_len[2*4 +: 4]    = 4'd3;
    req_valid            = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++;
      $display("FAIL single_grant got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    checks++; if (axi.ARVALID !== 1'b1 || axi.ARID !== 4'd2) begin errors++;
      $display("FAIL single_ar got valid %b id %0d want 1/2", axi.ARVALID, axi.ARID); end
    checks++; if (axi.ARADDR !== 32'h1000 || axi.ARLEN !== 4'd3) begin errors++;
      $display("FAIL single_addr got %h/%0d want 1000/3", axi.ARADDR, axi.ARLEN); end
    checks++; if (axi.ARSIZE !== 3'd6 || axi.ARBURST !== 2'b01 || axi.ARLOCK !== 2'b00)
      begin errors++; $display("FAIL single_const got size %0d burst %b lock %b want 6/01/00",
        axi.ARSIZE, axi.ARBURST, axi.ARLOCK); end
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    req_valid   = 4'b0100;
    #1;
    checks++; if (axi.ARVALID !== 1'b0 || req_ready !== 4'b0000) begin errors++;
      $display("FAIL single_outstanding got arvalid %b ready %b want 0/0000",
        axi.ARVALID, req_ready); end
    rsp_ready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      exp_data    = {16{32'hD00D_0000 + 32'(b)}};
      axi.RVALID  = 1'b1;
      axi.RID     = 4'd2;
      axi.RDATA   = exp_data;
      axi.RLAST   = (b == 3);
      #1;
      checks++; if (rsp_valid !== 4'b0100 || axi.RREADY !== 1'b1) begin errors++;
        $display("FAIL single_beat%0d got %b/%b want 0100/1", b, rsp_valid, axi.RREADY); end
      checks++; if (rsp_data !== exp_data) begin errors++;
        $display("FAIL single_data%0d got %h want %h", b, rsp_data[31:0], exp_data[31:0]); end
      if (b == 3) begin
        checks++; if (req_ready !== 4'b0000) begin errors++;
          $display("FAIL same_cycle_last got %b want 0000", req_ready); end
      end
      step();
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++;
      $display("FAIL single_regrant got %b want 0100", req_ready); end
    req_valid = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_gnt;
    do_reset();
    for (int k = 0; k < 4; k++) req_addr[k*AW +: AW] = 32'h2000 + 32'(k) * 32'h40;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_gnt = 4'b0001 << exp_seq[i];
      if (i > 0) begin
        axi.RVALID = 1'b1;
        axi.RID    = 4'(exp_seq[i-1]);
        axi.RLAST  = 1'b1;
      end
      #1;
      checks++; if (req_ready !== exp_gnt) begin errors++;
        $display("FAIL rr_grant%0d got %b want %b", i, req_ready, exp_gnt); end
      step();
      axi.RVALID  = 1'b0;
      axi.RLAST   = 1'b0;
      axi.ARREADY = 1'b1;
      #1;
      checks++; if (axi.ARID !== 4'(exp_seq[i]) || axi.ARADDR !== 32'h2000 + 32'(exp_seq[i]) * 32'h40)
        begin errors++; $display("FAIL rr_ar%0d got id %0d addr %h want %0d", i, axi.ARID,
          axi.ARADDR, exp_seq[i]); end
      step();
      axi.ARREADY = 1'b0;
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_ar_stall();
    int pulses;
    do_reset();
    pulses = 0;
    req_addr[1*AW +: AW] = 32'hABCD_0040;
    req_len[1*4 +: 4]    = 4'd7;
    req_valid            = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++;
      $display("FAIL stall_grant got %b want 0010", req_ready); end
    if (req_ready != '0) pulses++;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (axi.ARVALID !== 1'b1 || axi.ARADDR !== 32'hABCD_0040 || axi.ARLEN !== 4'd7)
        begin errors++; $display("FAIL stall_hold%0d got %b %h %0d want 1 abcd0040 7", c,
          axi.ARVALID, axi.ARADDR, axi.ARLEN); end
      if (req_ready != '0) pulses++;
      step();
    end
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (req_ready != '0) pulses++;
      step();
    end
    checks++; if (axi.ARVALID !== 1'b0) begin errors++;
      $display("FAIL stall_release got %b want 0", axi.ARVALID); end
    checks++; if (pulses !== 1) begin errors++;
      $display("FAIL stall_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_interleave();
    int          rid  [5] = '{1, 3, 1, 3, 1};
    logic        last [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  resp [5] = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    logic [NR-1:0] exp_v;
    rsp_ready = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      exp_v      = 4'b0001 << rid[i];
      axi.RVALID = 1'b1;
      axi.RID    = 4'(rid[i]);
      axi.RLAST  = last[i];
      axi.RRESP  = resp[i];
      #1;
      checks++; if (rsp_valid !== exp_v || axi.RREADY !== (rid[i] == 1)) begin errors++;
        $display("FAIL ilv_beat%0d got %b/%b want %b/%b", i, rsp_valid, axi.RREADY, exp_v,
          rid[i] == 1); end
      checks++; if (rsp_resp !== resp[i] || rsp_last !== last[i]) begin errors++;
        $display("FAIL ilv_pass%0d got %b/%b want %b/%b", i, rsp_resp, rsp_last, resp[i],
          last[i]); end
      step();
    end
    axi.RVALID = 1'b0;
    axi.RLAST  = 1'b0;
    axi.RRESP  = 2'b00;
    #1;
    checks++; if (req_ready !== 4'b0010 || id_err !== 1'b0) begin errors++;
      $display("FAIL ilv_release got %b err %b want 0010 0", req_ready, id_err); end
    req_valid = '0;
    step();
  endtask

  task automatic test_bad_id();
    rsp_ready  = 4'b0000;
    axi.RVALID = 1'b1;
    axi.RID    = 4'd7;
    #1;
    checks++; if (axi.RREADY !== 1'b1 || rsp_valid !== 4'b0000) begin errors++;
      $display("FAIL badid_drop got %b/%b want 1/0000", axi.RREADY, rsp_valid); end
    step();
    axi.RVALID = 1'b0;
    axi.RID    = 4'd0;
    checks++; if (id_err !== 1'b1) begin errors++;
      $display("FAIL badid_set got %b want 1", id_err); end
    step(); step(); step();
    checks++; if (id_err !== 1'b1) begin errors++;
      $display("FAIL badid_sticky got %b want 1", id_err); end
    do_reset();
    checks++; if (id_err !== 1'b0) begin errors++;
      $display("FAIL badid_clear got %b want 0", id_err); end
  endtask

  task automatic test_wdog_and_reset();
    do_reset();
    req_valid = 4'b0001;
    step();
    req_valid   = '0;
    axi.ARREADY = 1'b1;
    step();
    axi.ARREADY = 1'b0;
`ifdef AXI_RD_ARB_WDOG_EN
    for (int i = 1; i < 16; i++) step();
    checks++; if (wdog_err !== 1'b0) begin errors++;
      $display("FAIL wdog_early got %b want 0", wdog_err); end
    step();
    checks++; if (wdog_err !== 1'b1) begin errors++;
      $display("FAIL wdog_fire got %b want 1", wdog_err); end
`else
    for (int i = 0; i < 20; i++) step();
    checks++; if (wdog_err !== 1'b0) begin errors++;
      $display("FAIL wdog_tied got %b want 0", wdog_err); end
`endif
    req_addr[1*AW +: AW] = 32'h5555_0000;
    req_len[1*4 +: 4]    = 4'd9;
    req_valid            = 4'b0010;
    step();
    req_valid = '0;
    checks++; if (axi.ARVALID !== 1'b1 || axi.ARID !== 4'd1) begin errors++;
      $display("FAIL midrst_pre got %b/%0d want 1/1", axi.ARVALID, axi.ARID); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (axi.ARVALID !== 1'b0 || axi.ARID !== 4'd0 || axi.ARADDR !== 32'd0 ||
      axi.ARLEN !== 4'd0) begin errors++; $display("FAIL midrst_ar got %b %0d %h %0d want 0",
        axi.ARVALID, axi.ARID, axi.ARADDR, axi.ARLEN); end
    checks++; if (wdog_err !== 1'b0 || id_err !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_misc got %b %b %b want 0 0 0000", wdog_err, id_err,
        req_ready); end
    step();
    rst_n = 1'b1;
    step();
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL midrst_outstanding got %b want 0001", req_ready); end
    req_valid = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ar_stall();
    test_interleave();
    test_bad_id();
    test_wdog_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
